// File: rtl/fifo_srl_flagged.sv
// ============================================================================
// Module   : fifo_srl_flagged
// Brief    : Shift-register FIFO, first-word fall-through, registered flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_srl_flagged #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  output logic                              if_full_n,
  output logic                              if_almost_full_n,
  input  logic                              if_write_ce,
  input  logic                              if_write,
  input  logic [DATA_WIDTH-1:0]             if_din,
  output logic                              if_empty_n,
  output logic                              if_almost_empty_n,
  input  logic                              if_read_ce,
  input  logic                              if_read,
  output logic [DATA_WIDTH-1:0]             if_dout,
  input  logic                              if_flush,
  output logic [$clog2(DEPTH+1)-1:0]        if_count,
  output logic                              err_overflow,
  output logic                              err_underflow
);

  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_WIDTH-1:0] FULL_LEVEL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_LEVEL   = CNT_WIDTH'(DEPTH - AF_MARGIN);
  localparam logic [CNT_WIDTH-1:0] AE_LEVEL   = CNT_WIDTH'(AE_MARGIN);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_srl_flagged: DEPTH must be at least 2");
    end
    if (AF_MARGIN >= DEPTH) begin : g_bad_af
      $error("fifo_srl_flagged: AF_MARGIN must be less than DEPTH");
    end
    if (AE_MARGIN >= DEPTH) begin : g_bad_ae
      $error("fifo_srl_flagged: AE_MARGIN must be less than DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_full_n;
  logic                  r_almost_full_n;
  logic                  r_empty_n;
  logic                  r_almost_empty_n;
  logic                  r_err_overflow;
  logic                  r_err_underflow;

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CNT_WIDTH-1:0]  w_count_next;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  // Flush dominates: a flushed cycle neither stores data nor pops.
  assign w_wr_req = if_write & if_write_ce;
  assign w_rd_req = if_read & if_read_ce;
  assign w_wr_acc = w_wr_req & r_full_n & ~if_flush;
  assign w_rd_acc = w_rd_req & r_empty_n & ~if_flush;

  always_comb begin
    w_count_next = r_count;
    if (if_flush) begin
      w_count_next = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_next = r_count - ONE;
    end
  end

  // Storage carries no reset so it maps onto shift-register primitives.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count          <= '0;
      r_full_n         <= 1'b1;
      r_almost_full_n  <= 1'b1;
      r_empty_n        <= 1'b0;
      r_almost_empty_n <= 1'b0;
      r_err_overflow   <= 1'b0;
      r_err_underflow  <= 1'b0;
    end else begin
      r_count          <= w_count_next;
      r_full_n         <= (w_count_next != FULL_LEVEL);
      r_almost_full_n  <= (w_count_next < AF_LEVEL);
      r_empty_n        <= (w_count_next != '0);
      r_almost_empty_n <= (w_count_next > AE_LEVEL);
      if (if_flush) begin
        r_err_overflow  <= 1'b0;
        r_err_underflow <= 1'b0;
      end else begin
        r_err_overflow  <= r_err_overflow  | (w_wr_req & ~r_full_n);
        r_err_underflow <= r_err_underflow | (w_rd_req & ~r_empty_n);
      end
    end
  end

  // The oldest word sits at the deepest occupied stage.
  assign w_rd_addr = ADDR_WIDTH'(r_count - ONE);

  always_comb begin
    if_dout = mem[0];
    if (r_count != '0) begin
      if_dout = mem[w_rd_addr];
    end
  end

  assign if_count          = r_count;
  assign if_full_n         = r_full_n;
  assign if_almost_full_n  = r_almost_full_n;
  assign if_empty_n        = r_empty_n;
  assign if_almost_empty_n = r_almost_empty_n;
  assign err_overflow      = r_err_overflow;
  assign err_underflow     = r_err_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_srl_flagged.sv
// ============================================================================
// Module   : tb_fifo_srl_flagged
// Brief    : Directed bench for fifo_srl_flagged with a queue scoreboard
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_srl_flagged;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AFM   = 1;
  localparam int AEM   = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          if_full_n, if_almost_full_n, if_empty_n, if_almost_empty_n;
  logic          if_write_ce = 1'b0, if_write = 1'b0;
  logic          if_read_ce = 1'b0, if_read = 1'b0;
  logic          if_flush = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic [DW-1:0] if_dout;
  logic [2:0]    if_count;
  logic          err_overflow, err_underflow;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic          m_ov = 1'b0;
  logic          m_un = 1'b0;

  fifo_srl_flagged #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM), .AE_MARGIN(AEM)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_full_n(if_full_n), .if_almost_full_n(if_almost_full_n),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_empty_n(if_empty_n), .if_almost_empty_n(if_almost_empty_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
    .if_flush(if_flush), .if_count(if_count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},   32'(if_count), 32'(n));
    chk({tag, ".full_n"},  32'(if_full_n), 32'(n != DEPTH));
    chk({tag, ".af_n"},    32'(if_almost_full_n), 32'(n < DEPTH - AFM));
    chk({tag, ".empty_n"}, 32'(if_empty_n), 32'(n != 0));
    chk({tag, ".ae_n"},    32'(if_almost_empty_n), 32'(n > AEM));
    chk({tag, ".ovf"},     32'(err_overflow), 32'(m_ov));
    chk({tag, ".unf"},     32'(err_underflow), 32'(m_un));
    if (n > 0) chk({tag, ".dout"}, 32'(if_dout), 32'(q[0]));
  endtask

  // One clock edge with the given request pattern; the model is updated in step.
  task automatic step(input string tag, input logic w, input logic wce,
                      input logic [DW-1:0] d, input logic r, input logic rce,
                      input logic f);
    logic wa, ra;
    if_write = w; if_write_ce = wce; if_din = d;
    if_read = r; if_read_ce = rce; if_flush = f;
    wa = w && wce && (q.size() < DEPTH) && !f;
    ra = r && rce && (q.size() > 0) && !f;
    @(posedge clk);
    #1;
    if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0;
    if_read_ce = 1'b0; if_flush = 1'b0;
    if (f) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (w && wce && q.size() == DEPTH) m_ov = 1'b1;
      if (r && rce && q.size() == 0) m_un = 1'b1;
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
    end
    chk_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  initial begin
    // Reset takes effect immediately, away from any clock edge.
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("rst_async");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_hold");

    step("fill1", 1, 1, 8'h11, 0, 0, 0);
    chk("fill1.ae_n_low", 32'(if_almost_empty_n), 32'd0);
    step("fill2", 1, 1, 8'h22, 0, 0, 0);
    chk("fill2.ae_n_high", 32'(if_almost_empty_n), 32'd1);
    step("fill3", 1, 1, 8'h33, 0, 0, 0);
    chk("fill3.af_n_low", 32'(if_almost_full_n), 32'd0);
    step("fill4", 1, 1, 8'h44, 0, 0, 0);
    chk("fill4.full_n_low", 32'(if_full_n), 32'd0);
    chk("fill4.dout", 32'(if_dout), 32'h11);

    step("full_rw", 1, 1, 8'h55, 1, 1, 0);
    chk("full_rw.count", 32'(if_count), 32'd3);
    chk("full_rw.dout", 32'(if_dout), 32'h22);
    chk("full_rw.ovf", 32'(err_overflow), 32'd1);

    step("ce_low_wr", 1, 0, 8'h99, 0, 0, 0);
    step("ce_low_rd", 0, 0, 8'h00, 1, 0, 0);

    step("flush", 1, 1, 8'h77, 1, 1, 1);
    chk("flush.count", 32'(if_count), 32'd0);
    step("post_flush_wr", 1, 1, 8'h88, 0, 0, 0);
    chk("post_flush.dout", 32'(if_dout), 32'h88);
    step("drain", 0, 0, 8'h00, 1, 1, 0);

    step("wA0", 1, 1, 8'hA0, 0, 0, 0);
    step("wA1", 1, 1, 8'hA1, 0, 0, 0);
    step("strm1", 1, 1, 8'hA2, 1, 1, 0);
    chk("strm1.dout", 32'(if_dout), 32'hA1);
    step("strm2", 1, 1, 8'hA3, 1, 1, 0);
    chk("strm2.dout", 32'(if_dout), 32'hA2);
    step("strm3", 1, 1, 8'hA4, 1, 1, 0);
    chk("strm3.dout", 32'(if_dout), 32'hA3);
    chk("strm3.count", 32'(if_count), 32'd2);

    step("to3", 1, 1, 8'hB0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("mid_rst");
    #3 reset_n = 1'b1;
    step("empty_rd", 0, 0, 8'h00, 1, 1, 0);
    chk("empty_rd.unf", 32'(err_underflow), 32'd1);

    step("empty_rw", 1, 1, 8'hC3, 1, 1, 0);
    chk("empty_rw.count", 32'(if_count), 32'd1);
    step("read_last", 0, 0, 8'h00, 1, 1, 0);
    step("flush_clr", 0, 0, 8'h00, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_srl_flagged.md
FIFO_SRL_FLAGGED -- requirements
Module: fifo_srl_flagged

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, the entry count; DEPTH < 2 is an elaboration error.
REQ-003 SHALL have parameter AF_MARGIN, default 2, the almost-full threshold distance; AF_MARGIN >= DEPTH is an elaboration error.
REQ-004 SHALL have parameter AE_MARGIN, default 2, the almost-empty threshold; AE_MARGIN >= DEPTH is an elaboration error.
REQ-005 SHALL have local CNT_WIDTH = clog2(DEPTH+1).
REQ-006 SHALL have ports, in this order:
  clk  in  1  single clock; all sequential logic on the rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  if_full_n  out  1  low = full, write refused.
  if_almost_full_n  out  1  low = count >= DEPTH-AF_MARGIN.
  if_write_ce  in  1  write clock-enable.
  if_write  in  1  write request.
  if_din  in  DATA_WIDTH  write data.
  if_empty_n  out  1  low = empty.
  if_almost_empty_n  out  1  low = count <= AE_MARGIN.
  if_read_ce  in  1  read clock-enable.
  if_read  in  1  read request (pop).
  if_dout  out  DATA_WIDTH  oldest entry, first-word fall-through.
  if_flush  in  1  synchronous discard of all contents.
  if_count  out  CNT_WIDTH  current occupancy.
  err_overflow  out  1  sticky: write attempted while full.
  err_underflow  out  1  sticky: read attempted while empty.

Function
REQ-007 SHALL accept a write (wr_acc) iff if_write & if_write_ce & if_full_n.
REQ-008 SHALL accept a read (rd_acc) iff if_read & if_read_ce & if_empty_n.
REQ-009 SHALL store data in a shift register (new word at index 0, shift on wr_acc only), with no reset of storage, so it infers SRL.
REQ-010 SHALL drive if_dout = mem[count-1] combinationally when count > 0, and mem[0] when count = 0.
REQ-011 SHALL update count on each edge: +1 for wr_acc only, -1 for rd_acc only, unchanged for both or neither.
REQ-012 SHALL register all flags from the next count, so flags change on the same edge as if_count.
REQ-013 SHALL give a write-to-visible latency of one edge: a word written at edge N shows on if_dout with if_empty_n=1 after edge N.
REQ-014 SHALL, when full, refuse any write even if a read is accepted the same cycle; the read alone proceeds.
REQ-015 SHALL, when empty, refuse any read even if a write is accepted the same cycle; the write alone proceeds.
REQ-016 SHALL set err_overflow on an edge where if_write & if_write_ce & !if_full_n; it holds until flush or reset.
REQ-017 SHALL set err_underflow on an edge where if_read & if_read_ce & !if_empty_n; it holds until flush or reset.
REQ-018 SHALL, on if_flush=1 at an edge, override simultaneous read/write: count=0, if_empty_n=0, if_full_n=1, if_almost_full_n=1, if_almost_empty_n=0, both err flags cleared, the write dropped, and no error set that cycle.
REQ-019 SHALL never let count wrap: it stays in 0..DEPTH.

Reset
REQ-020 SHALL, while reset_n=0 and without waiting for a clock edge, force: if_count=0, if_empty_n=0, if_full_n=1, if_almost_full_n=1, if_almost_empty_n=0, err_overflow=0, err_underflow=0.
REQ-021 SHALL, on the first edge after reset_n rises, accept a write if one is presented.
REQ-022 SHALL not clear storage contents on reset; if_dout is unspecified until the first write.

Verification (DEPTH=4, DATA_WIDTH=8, AF_MARGIN=1, AE_MARGIN=1)
REQ-023 Reset: assert reset_n=0 -> all outputs take the REQ-020 values immediately; release -> values hold.
REQ-024 Fill: write 0x11,0x22,0x33,0x44 on consecutive edges ->
  count goes 1,2,3,4;
  almost_empty_n rises after the 2nd write;
  almost_full_n falls after the 3rd write;
  full_n falls after the 4th write;
  if_dout=0x11 from after the 1st write.
REQ-025 Full push+pop: from full, write 0x55 and read together -> read accepted, write refused, err_overflow=1, count=3, if_dout=0x22.
REQ-026 Steady stream: at count=2 (0xA0,0xA1), read+write 0xA2 for 3 edges with writes 0xA2,0xA3,0xA4 -> count stays 2; if_dout sequence 0xA1,0xA2,0xA3.
REQ-027 Flush: at count=3, raise flush with write 0x77 and read -> count=0, empty_n=0, errs=0; the next write 0x88 appears as if_dout=0x88.
REQ-028 Mid-operation reset: drop reset_n between edges at count=3 -> flags and count reach reset values before the next edge; empty-read after release sets err_underflow=1.
